// File: rtl/aes_inv_seq_ctrl.sv
// Request/response sequencer in front of an AES-128 inverse cipher core.
// Optional last-key cache is enabled by defining AES_INV_SEQ_KEY_CACHE_EN.
module aes_inv_seq_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [127:0]     req_key,
  input  logic [127:0]     req_text,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_text,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             core_kld,
  output logic [127:0]     core_key,
  output logic             core_ld,
  output logic [127:0]     core_text_in,
  input  logic             core_kdone,
  input  logic             core_done,
  input  logic [127:0]     core_text_out
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KLOAD = 3'd1,
    KWAIT = 3'd2,
    DLOAD = 3'd3,
    DWAIT = 3'd4,
    RESP  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [127:0]      rsp_text_q, rsp_text_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;
  logic              core_kld_q, core_kld_d;
  logic              core_ld_q, core_ld_d;
  logic [127:0]      core_key_q, core_key_d;
  logic [127:0]      core_text_in_q, core_text_in_d;

  logic              wd_expired;
  logic              cache_hit;
  logic              cache_set;
  logic              cache_clr;

  assign wd_expired = (wdog_q == WD_W'(TIMEOUT - 1));

`ifdef AES_INV_SEQ_KEY_CACHE_EN
  logic [127:0] cache_key_q, cache_key_d;
  logic         cache_vld_q, cache_vld_d;

  assign cache_hit = cache_vld_q && (req_key == cache_key_q);

  // Cache remembers the key whose schedule the core last finished expanding.
  always_comb begin
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    if (cache_clr) begin
      cache_vld_d = 1'b0;
    end else if (cache_set) begin
      cache_key_d = core_key_q;
      cache_vld_d = 1'b1;
    end else begin
      cache_vld_d = cache_vld_q;
    end
  end

  // Cache registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_key_q <= 128'd0;
      cache_vld_q <= 1'b0;
    end else begin
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`else
  logic unused_cache;

  assign cache_hit    = 1'b0;
  assign unused_cache = cache_set | cache_clr;
`endif

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    wdog_d         = wdog_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_text_d     = rsp_text_q;
    rsp_tag_d      = rsp_tag_q;
    rsp_err_d      = rsp_err_q;
    core_kld_d     = 1'b0;
    core_ld_d      = 1'b0;
    core_key_d     = core_key_q;
    core_text_in_d = core_text_in_q;
    cache_set      = 1'b0;
    cache_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d    = 1'b0;
          core_key_d     = req_key;
          core_text_in_d = req_text;
          rsp_tag_d      = req_tag;
          if (cache_hit) begin
            core_ld_d = 1'b1;
            state_d   = DLOAD;
          end else begin
            core_kld_d = 1'b1;
            state_d    = KLOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      KLOAD: begin
        wdog_d  = '0;
        state_d = KWAIT;
      end

      // kdone may still be stale from the previous key in the first cycle.
      KWAIT: begin
        if ((wdog_q != '0) && core_kdone) begin
          cache_set = 1'b1;
          core_ld_d = 1'b1;
          state_d   = DLOAD;
        end else if (wd_expired) begin
          rsp_text_d  = 128'd0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cache_clr   = 1'b1;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      DLOAD: begin
        wdog_d  = '0;
        state_d = DWAIT;
      end

      DWAIT: begin
        if (core_done) begin
          rsp_text_d  = core_text_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          rsp_text_d  = 128'd0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cache_clr   = 1'b1;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready && rsp_valid_q) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wdog_q         <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_text_q     <= 128'd0;
      rsp_tag_q      <= '0;
      rsp_err_q      <= 1'b0;
      core_kld_q     <= 1'b0;
      core_ld_q      <= 1'b0;
      core_key_q     <= 128'd0;
      core_text_in_q <= 128'd0;
    end else begin
      state_q        <= state_d;
      wdog_q         <= wdog_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_text_q     <= rsp_text_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_err_q      <= rsp_err_d;
      core_kld_q     <= core_kld_d;
      core_ld_q      <= core_ld_d;
      core_key_q     <= core_key_d;
      core_text_in_q <= core_text_in_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_text     = rsp_text_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_err      = rsp_err_q;
  assign core_kld     = core_kld_q;
  assign core_ld      = core_ld_q;
  assign core_key     = core_key_q;
  assign core_text_in = core_text_in_q;

endmodule

// File: tb/tb_aes_inv_seq_ctrl.sv
// Bench for aes_inv_seq_ctrl: behavioural core stub, vector table, scoreboard,
// and hand-written sequences for backpressure, timeout, stray strobes and reset.
module tb_aes_inv_seq_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

`ifdef AES_INV_SEQ_KEY_CACHE_EN
  localparam int HIT_KLD = 0;
`else
  localparam int HIT_KLD = 1;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIST_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] NIST_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [127:0] req_key = 128'd0;
  logic [127:0] req_text = 128'd0;
  logic [TAG_W-1:0] req_tag = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [127:0] rsp_text;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_err;
  logic core_kld, core_ld;
  logic [127:0] core_key, core_text_in;
  logic core_kdone, core_done;
  logic [127:0] core_text_out;

  always #5 clk = ~clk;

  aes_inv_seq_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_text(rsp_text), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .core_kld(core_kld), .core_key(core_key),
    .core_ld(core_ld), .core_text_in(core_text_in),
    .core_kdone(core_kdone), .core_done(core_done), .core_text_out(core_text_out)
  );

  // Stand-in for the inverse cipher: known FIPS/NIST pairs, otherwise a fixed mix.
  function automatic logic [127:0] model_pt(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    else if (k == NIST_KEY && c == NIST_CT) return NIST_PT;
    else return k ^ {c[63:0], c[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
  endfunction

  // ---------------- core stub ----------------
  int kdly = 2;
  int ddly = 2;
  bit hang = 1'b0;
  logic stray_done = 1'b0;
  logic kdone_q = 1'b0;
  logic done_q = 1'b0;
  logic [127:0] text_out_q = 128'd0;
  logic [127:0] ks_key = 128'd0;
  logic [127:0] ld_text = 128'd0;
  bit ks_valid = 1'b0;
  int kcnt = 0;
  int dcnt = 0;
  int stub_errs = 0;

  assign core_kdone    = kdone_q;
  assign core_done     = done_q | stray_done;
  assign core_text_out = text_out_q;

  always @(posedge clk) begin
    if (core_kld) begin
      kdone_q  <= 1'b0;
      ks_valid <= 1'b0;
      ks_key   <= core_key;
      kcnt     <= kdly;
    end else if (kcnt != 0) begin
      kcnt <= kcnt - 1;
      if (kcnt == 1) begin
        kdone_q  <= 1'b1;
        ks_valid <= 1'b1;
      end
    end
    done_q     <= 1'b0;
    text_out_q <= {$urandom, $urandom, $urandom, $urandom};
    if (core_ld) begin
      if (!ks_valid || core_key !== ks_key) begin
        stub_errs <= stub_errs + 1;
        $display("FAIL core_ld_without_schedule: key %h scheduled %h valid %0d", core_key, ks_key, ks_valid);
      end
      ld_text <= core_text_in;
      dcnt    <= hang ? 0 : ddly;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        done_q     <= 1'b1;
        text_out_q <= model_pt(ks_key, ld_text);
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int kld_total = 0;
  int ld_total = 0;
  int ld_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_kld) kld_total <= kld_total + 1;
    if (core_ld) begin
      ld_total <= ld_total + 1;
      ld_cyc   <= cyc;
    end
    if (core_kld && core_ld) begin
      stub_errs <= stub_errs + 1;
      $display("FAIL kld_ld_overlap: both strobes high at cycle %0d", cyc);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0]     text;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sbq[$];
  int rsp_cyc = 0;

  task automatic do_req(input logic [127:0] k, input logic [127:0] t, input logic [TAG_W-1:0] g,
                        input logic [127:0] ep, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    req_key = k; req_text = t; req_tag = g; req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", 400'(req_ready), 400'(1'b1));
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_text = {$urandom, $urandom, $urandom, $urandom};
      sbq.push_back('{text: ep, tag: g, err: ee});
    end
  endtask

  task automatic get_rsp(input int hold);
    int n;
    exp_t e;
    n = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_wait", 400'(rsp_valid), 400'(1'b1));
    end else begin
      rsp_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 400'(sbq.size()), 400'(1));
      end else begin
        e = sbq.pop_front();
        chk("rsp_text", 400'(rsp_text), 400'(e.text));
        chk("rsp_tag", 400'(rsp_tag), 400'(e.tag));
        chk("rsp_err", 400'(rsp_err), 400'(e.err));
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk("rsp_hold", 400'({rsp_valid, req_ready, rsp_err, rsp_tag, rsp_text}),
              400'({1'b1, 1'b0, e.err, e.tag, e.text}));
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_valid_drop", 400'(rsp_valid), 400'(1'b0));
    end
  endtask

  function automatic logic [399:0] all_outs();
    return 400'({req_ready, rsp_valid, rsp_err, rsp_tag, rsp_text,
                 core_kld, core_ld, core_key, core_text_in});
  endfunction

  typedef struct {
    logic [127:0]     key;
    logic [127:0]     text;
    logic [TAG_W-1:0] tag;
    int               kd;
    int               dd;
    logic [127:0]     exp_text;
    int               exp_kld;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k0;
    int l0;
    int seen;

    vecs[0] = '{FIPS_KEY, FIPS_CT, 4'd3, 1, 1, FIPS_PT, 1};
    vecs[1] = '{FIPS_KEY, FIPS_CT, 4'd1, 3, 4, FIPS_PT, HIT_KLD};
    vecs[2] = '{FIPS_KEY, FIPS_CT, 4'd2, 2, 2, FIPS_PT, HIT_KLD};
    vecs[3] = '{NIST_KEY, NIST_CT, 4'd4, 5, 7, NIST_PT, 1};
    vecs[4] = '{NIST_KEY, 128'hdeadbeef_01234567_cafef00d_89abcdef, 4'd6, 1, 1,
                model_pt(NIST_KEY, 128'hdeadbeef_01234567_cafef00d_89abcdef), HIT_KLD};
    vecs[5] = '{FIPS_KEY, FIPS_CT, 4'd7, 2, 3, FIPS_PT, 1};

    // Reset state, then the first cycle out of reset, then IDLE ready.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 400'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset0", 400'(req_ready), 400'(1'b0));
    @(negedge clk);
    chk("ready_after_reset1", 400'(req_ready), 400'(1'b1));

    for (int i = 0; i < 6; i++) begin
      kdly = vecs[i].kd;
      ddly = vecs[i].dd;
      k0 = kld_total;
      l0 = ld_total;
      do_req(vecs[i].key, vecs[i].text, vecs[i].tag, vecs[i].exp_text, 1'b0);
      get_rsp(0);
      chk($sformatf("kld_pulses_v%0d", i), 400'(kld_total - k0), 400'(vecs[i].exp_kld));
      chk($sformatf("ld_pulses_v%0d", i), 400'(ld_total - l0), 400'(1));
    end

    // Response backpressure for 20 cycles.
    kdly = 2; ddly = 2;
    do_req(NIST_KEY, NIST_CT, 4'd11, NIST_PT, 1'b0);
    get_rsp(20);

    // Stray strobes while idle are ignored.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_done_ignored", 400'({rsp_valid, req_ready}), 400'({1'b0, 1'b1}));

    // Watchdog timeout in DWAIT, then same key must reload the schedule.
    hang = 1'b1;
    do_req(FIPS_KEY, FIPS_CT, 4'd9, 128'd0, 1'b1);
    get_rsp(0);
    chk("timeout_latency", 400'(rsp_cyc - ld_cyc), 400'(TIMEOUT + 1));
    hang = 1'b0;
    k0 = kld_total;
    do_req(FIPS_KEY, FIPS_CT, 4'd10, FIPS_PT, 1'b0);
    get_rsp(0);
    chk("kld_after_timeout", 400'(kld_total - k0), 400'(1));

    // Reset for one cycle during DWAIT abandons the request.
    kdly = 2; ddly = 30;
    do_req(NIST_KEY, NIST_CT, 4'd12, NIST_PT, 1'b0);
    void'(sbq.pop_back());
    seen = 0;
    while (!core_ld && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("ld_before_reset", 400'(core_ld), 400'(1'b1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midop_reset_outputs", all_outs(), 400'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 400'(seen), 400'(0));
    kdly = 3; ddly = 2;
    k0 = kld_total;
    do_req(NIST_KEY, NIST_CT, 4'd13, NIST_PT, 1'b0);
    get_rsp(0);
    chk("kld_after_reset", 400'(kld_total - k0), 400'(1));

    repeat (2) @(negedge clk);
    chk("stub_protocol", 400'(stub_errs), 400'(0));
    chk("scoreboard_drained", 400'(sbq.size()), 400'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
